// File: rtl/taylor_sincos_pkg.sv
// Shared types and constant helpers for the Taylor-series sine/cosine engine.
package taylor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SQUARE = 2'd1,
    ST_ITER   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // round(pi/2 * 2^frac); int'() of a real rounds to nearest.
  function automatic int pi_half(input int frac);
    return int'(1.5707963267948966 * real'(longint'(1) << frac));
  endfunction

  // Per-term recurrence coefficient round(2^frac / d); mode 0 = cosine, 1 = sine.
  function automatic longint coef(input int k, input logic mode, input int frac);
    longint d;
    d = mode ? longint'((2 * k) * (2 * k + 1)) : longint'((2 * k - 1) * (2 * k));
    if (d <= 0) return 0;
    return ((longint'(1) << frac) + d / 2) / d;
  endfunction

endpackage

// File: rtl/taylor_fxp_mul.sv
// Combinational signed fixed-point multiply with round-half-up on the dropped fraction.
module taylor_fxp_mul #(
  parameter int WIDTH = 24,
  parameter int FRAC  = 10
) (
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  output logic signed [WIDTH-1:0] o_p
);

  localparam logic signed [2*WIDTH-1:0] HALF = (2*WIDTH)'(1) <<< (FRAC - 1);

  logic signed [2*WIDTH-1:0] w_full;
  logic signed [2*WIDTH-1:0] w_rnd;

  assign w_full = i_a * i_b;
  assign w_rnd  = w_full + HALF;
  assign o_p    = WIDTH'(w_rnd >>> FRAC);

endmodule

// File: rtl/taylor_sincos.sv
// Iterative Taylor-series cosine/sine: one square cycle, then one series term per cycle.
module taylor_sincos
  import taylor_pkg::*;
#(
  parameter int WIDTH   = 24,
  parameter int FRAC    = 10,
  parameter int N_TERMS = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mode_in,
  input  logic signed [WIDTH-1:0] angle_in,
  output logic                    ready_out,
  output logic                    busy_out,
  output logic                    err_out,
  output logic signed [WIDTH-1:0] result_out,
  output state_t                  dbg_state_out
);

  localparam logic signed [WIDTH-1:0] ONE  = WIDTH'(1) <<< FRAC;
  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH:0]   PI_H = (WIDTH+1)'(pi_half(FRAC));

  state_t                  r_state, w_state_next;
  logic                    r_mode, r_err, r_err_out;
  logic signed [WIDTH-1:0] r_x, r_x2, r_term, r_result;
  logic signed [WIDTH+1:0] r_sum;
  logic [2:0]              r_k;

  logic                    w_accept, w_last;
  logic signed [WIDTH-1:0] w_mul_a, w_mul_b, w_p1, w_term_next, w_coef, w_sat;
  logic signed [WIDTH+1:0] w_term_ext, w_sum_next;
  logic signed [WIDTH:0]   w_x_ext, w_abs;
  logic signed [WIDTH-1:0] w_coef_tab [2][8];

  for (genvar m = 0; m < 2; m++) begin : g_mode
    for (genvar g = 0; g < 8; g++) begin : g_coef
      assign w_coef_tab[m][g] = WIDTH'(coef(g, 1'(m), FRAC));
    end
  end

  // Multiplier 0 squares the angle in SQUARE and forms term*x2 in ITER.
  assign w_mul_a = (r_state == ST_ITER) ? r_term : r_x;
  assign w_mul_b = (r_state == ST_ITER) ? r_x2   : r_x;
  assign w_coef  = w_coef_tab[r_mode][r_k];

  taylor_fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_sq (
    .i_a(w_mul_a), .i_b(w_mul_b), .o_p(w_p1)
  );
  taylor_fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_coef (
    .i_a(w_p1), .i_b(w_coef), .o_p(w_term_next)
  );

  assign w_term_ext = (WIDTH+2)'(w_term_next);
  assign w_sum_next = r_k[0] ? r_sum - w_term_ext : r_sum + w_term_ext;
  assign w_last     = (r_k == 3'(N_TERMS - 1));
  assign w_x_ext    = {r_x[WIDTH-1], r_x};
  assign w_abs      = r_x[WIDTH-1] ? -w_x_ext : w_x_ext;

  always_comb begin
    w_sat = w_sum_next[WIDTH-1:0];
    if (w_sum_next > (WIDTH+2)'(SMAX))      w_sat = SMAX;
    else if (w_sum_next < (WIDTH+2)'(SMIN)) w_sat = SMIN;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        w_state_next = ST_IDLE;
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = ST_SQUARE;
        end
      end
      ST_SQUARE: w_state_next = ST_ITER;
      ST_ITER:   if (w_last) w_state_next = ST_DONE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_mode    <= 1'b0;
      r_err     <= 1'b0;
      r_err_out <= 1'b0;
      r_x       <= '0;
      r_x2      <= '0;
      r_term    <= '0;
      r_result  <= '0;
      r_sum     <= '0;
      r_k       <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_x    <= angle_in;
        r_mode <= mode_in;
      end
      case (r_state)
        ST_SQUARE: begin
          r_x2   <= w_p1;
          r_term <= r_mode ? r_x : ONE;
          r_sum  <= (WIDTH+2)'(r_mode ? r_x : ONE);
          r_k    <= 3'd1;
          r_err  <= (w_abs > PI_H);
        end
        ST_ITER: begin
          r_term <= w_term_next;
          r_sum  <= w_sum_next;
          r_k    <= r_k + 3'd1;
          if (w_last) begin
            r_result  <= r_err ? '0 : w_sat;
            r_err_out <= r_err;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_out     = (r_state == ST_DONE);
  assign busy_out      = (r_state != ST_IDLE);
  assign err_out       = r_err_out;
  assign result_out    = r_result;
  assign dbg_state_out = r_state;

endmodule

// File: tb/tb_taylor_sincos.sv
// Bench for taylor_sincos: vector table, random angles against real sin/cos, handshake corner cases.
module tb_taylor_sincos;
  import taylor_pkg::*;

  localparam int W = 24;

  logic clk = 1'b0;
  logic rst;
  logic start, mode_in, start6, mode6;
  logic signed [W-1:0] angle_in, angle6;
  logic ready, busy, err, ready6, busy6, err6;
  logic signed [W-1:0] result, result6;
  state_t dbg, dbg6;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic m;
    int   angle;
    int   exp;
    int   tol;
    logic exp_err;
  } vec_t;

  vec_t tbl [12];

  always #5 clk = ~clk;

  taylor_sincos #(.WIDTH(24), .FRAC(10), .N_TERMS(4)) dut (
    .clock(clk), .reset(rst), .start(start), .mode_in(mode_in), .angle_in(angle_in),
    .ready_out(ready), .busy_out(busy), .err_out(err), .result_out(result),
    .dbg_state_out(dbg)
  );

  taylor_sincos #(.WIDTH(24), .FRAC(16), .N_TERMS(6)) dut6 (
    .clock(clk), .reset(rst), .start(start6), .mode_in(mode6), .angle_in(angle6),
    .ready_out(ready6), .busy_out(busy6), .err_out(err6), .result_out(result6),
    .dbg_state_out(dbg6)
  );

  task automatic check(input string name, input int act, input int exp, input int tol);
    int d;
    d = act - exp;
    if (d < 0) d = -d;
    checks++;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (+/-%0d)", name, act, exp, tol);
    end
  endtask

  // Issue one request from idle; returns at the negedge where ready_out is seen.
  task automatic run_op(input logic m, input int a, output int res, output int e,
                        output int lat, output int busy1);
    @(negedge clk);
    start = 1'b1; mode_in = m; angle_in = W'(a);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy1 = int'(busy);
    while (!ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = int'(result);
    e = int'(err);
  endtask

  task automatic run_op6(input logic m, input int a, output int res, output int e,
                         output int lat);
    @(negedge clk);
    start6 = 1'b1; mode6 = m; angle6 = W'(a);
    @(negedge clk);
    start6 = 1'b0;
    lat = 1;
    while (!ready6 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = int'(result6);
    e = int'(err6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int res, e, lat, b1, pulses, first, a, exp_v, tol;
    logic m, exp_e;
    real rv;

    tbl[0]  = '{1'b0,   512,  899, 2, 1'b0};
    tbl[1]  = '{1'b1,   512,  491, 2, 1'b0};
    tbl[2]  = '{1'b1,  -512, -491, 2, 1'b0};
    tbl[3]  = '{1'b0,  -512,  899, 2, 1'b0};
    tbl[4]  = '{1'b0,     0, 1024, 0, 1'b0};
    tbl[5]  = '{1'b1,     0,    0, 0, 1'b0};
    tbl[6]  = '{1'b0,  1608,    0, 3, 1'b0};
    tbl[7]  = '{1'b1,  1608, 1024, 3, 1'b0};
    tbl[8]  = '{1'b0,  1638,    0, 0, 1'b1};
    tbl[9]  = '{1'b1, -1638,    0, 0, 1'b1};
    tbl[10] = '{1'b0,  1609,    0, 0, 1'b1};
    tbl[11] = '{1'b1, -1608, -1024, 3, 1'b0};

    // clock/reset
    rst = 1'b1; start = 1'b0; mode_in = 1'b0; angle_in = '0;
    start6 = 1'b0; mode6 = 1'b0; angle6 = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", int'(ready), 0, 0);
    check("reset_busy", int'(busy), 0, 0);
    check("reset_err", int'(err), 0, 0);
    check("reset_result", int'(result), 0, 0);
    check("reset_state", int'(dbg), 0, 0);
    check("reset6_result", int'(result6), 0, 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      run_op(tbl[i].m, tbl[i].angle, res, e, lat, b1);
      check($sformatf("vec%0d_latency", i), lat, 5, 0);
      check($sformatf("vec%0d_busy", i), b1, 1, 0);
      check($sformatf("vec%0d_err", i), e, int'(tbl[i].exp_err), 0);
      check($sformatf("vec%0d_result", i), res, tbl[i].exp, tbl[i].tol);
    end

    // random angles against the real-valued functions
    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom_range(0, 1));
      a = int'($urandom_range(0, 3400)) - 1700;
      if (a > 1608 || a < -1608) begin
        exp_e = 1'b1; exp_v = 0; tol = 0;
      end else begin
        rv = m ? $sin(real'(a) / 1024.0) : $cos(real'(a) / 1024.0);
        exp_e = 1'b0; exp_v = int'(rv * 1024.0); tol = 4;
      end
      run_op(m, a, res, e, lat, b1);
      check($sformatf("rand%0d_latency", i), lat, 5, 0);
      check($sformatf("rand%0d_err", i), e, int'(exp_e), 0);
      check($sformatf("rand%0d_result m=%0d a=%0d", i, m, a), res, exp_v, tol);
    end

    // start held for three cycles: one accept, result held while idle
    @(negedge clk);
    start = 1'b1; mode_in = 1'b0; angle_in = 24'sd512;
    pulses = 0; first = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 3) start = 1'b0;
      if (ready) begin
        pulses++;
        if (first == 0) first = c;
      end
      if (c == 9 || c == 12) check($sformatf("hold_result_c%0d", c), int'(result), 899, 2);
    end
    check("held_start_pulses", pulses, 1, 0);
    check("held_start_latency", first, 5, 0);
    check("held_start_idle_busy", int'(busy), 0, 0);

    // back-to-back: new start while in DONE
    run_op(1'b0, 512, res, e, lat, b1);
    check("b2b_first_result", res, 899, 2);
    start = 1'b1; mode_in = 1'b1; angle_in = 24'sd512;
    first = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        check("b2b_busy_c1", int'(busy), 1, 0);
      end
      if (ready && first == 0) begin
        first = c;
        check("b2b_second_result", int'(result), 491, 2);
      end
    end
    check("b2b_second_latency", first, 5, 0);

    // reset during ITER aborts without a ready pulse
    run_op(1'b0, 512, res, e, lat, b1);
    @(negedge clk);
    start = 1'b1; mode_in = 1'b0; angle_in = 24'sd512;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_state", int'(dbg), 0, 0);
    check("abort_busy", int'(busy), 0, 0);
    check("abort_ready", int'(ready), 0, 0);
    check("abort_result", int'(result), 0, 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    check("abort_no_ready", pulses, 0, 0);
    run_op(1'b0, 512, res, e, lat, b1);
    check("rerun_latency", lat, 5, 0);
    check("rerun_result", res, 899, 2);

    // six terms, 16 fraction bits
    run_op6(1'b0, 32768, res, e, lat);
    check("n6_latency", lat, 7, 0);
    check("n6_err", e, 0, 0);
    check("n6_cos_half", res, 57513, 4);
    run_op6(1'b1, 32768, res, e, lat);
    rv = $sin(0.5) * 65536.0;
    check("n6_sin_half", res, int'(rv), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/taylor_sincos.md
TAYLOR_SINCOS -- requirements
Module: taylor_sincos

Interface
REQ-001 Parameter WIDTH, default 24, total bits of the signed two's-complement fixed-point angle and result.
REQ-002 Parameter FRAC, default 10, fractional bits (Q(WIDTH-FRAC).FRAC); legal range 8..WIDTH-4.
REQ-003 Parameter N_TERMS, default 4, number of Taylor terms summed including the leading term; legal range 2..8.
REQ-004 clock  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request; sampled only in IDLE or DONE.
REQ-007 mode_in  input  1  0 = cosine, 1 = sine; captured with angle_in at accept.
REQ-008 angle_in  input  WIDTH  signed angle in radians, Q.FRAC; captured at accept.
REQ-009 ready_out  output  1  one-cycle pulse marking a valid result_out.
REQ-010 busy_out  output  1  high from the cycle after accept until the cycle after ready_out.
REQ-011 err_out  output  1  range error flag, valid with ready_out.
REQ-012 result_out  output  WIDTH  signed result, Q.FRAC; held stable until the next accept.

Function
REQ-013 FSM states IDLE, SQUARE, ITER, DONE.
REQ-014 Accept = start high in IDLE or DONE; capture angle_in and mode_in; go to SQUARE; start in SQUARE/ITER ignored.
REQ-015 SQUARE (1 cycle): x2 = round(x*x); term = 1.0 (cos) or x (sin); sum = term; k = 1; range check.
REQ-016 ITER (N_TERMS-1 cycles): term = round(round(term*x2) * C[k]); sum = sum - term if k odd, sum + term if k even; k increments; exit to DONE when k = N_TERMS-1.
REQ-017 C[k] = 1/((2k-1)(2k)) for cosine, 1/((2k)(2k+1)) for sine, each rounded to Q.FRAC.
REQ-018 DONE (1 cycle): ready_out = 1, result_out = sum; next state IDLE unless a start is accepted.
REQ-019 Latency: ready_out asserts exactly N_TERMS+1 cycles after the accepting edge (default 5).
REQ-020 Multiply: full 2*WIDTH signed product, add 2^(FRAC-1), arithmetic shift right FRAC, truncate to WIDTH.
REQ-021 Sum: WIDTH+2 bits internally; result saturates to signed WIDTH limits.
REQ-022 Range: |angle| > PI_HALF (round(pi/2 * 2^FRAC)) sets err_out = 1 with ready_out; result_out = 0; latency unchanged.
REQ-023 Back-to-back: start high during DONE is accepted; next ready_out follows N_TERMS+1 cycles later.

Reset
REQ-024 Reset forces IDLE; ready_out, busy_out, err_out, result_out, and all internal registers = 0.
REQ-025 Reset mid-operation aborts with no ready_out pulse; first accept after release behaves as from power-up.

Structure
REQ-026 Package taylor_pkg holds state enum, PI_HALF function of FRAC, and constant function coef(k, mode, frac) returning round(2^frac/d).
REQ-027 One sub-module taylor_fxp_mul: parametrised signed rounding fixed-point multiplier per REQ-020, combinational, instantiated twice.

Verification
REQ-028 Default params, mode 0, angle 512 (0.5) -> ready_out 5 cycles after accept, result 899 +/-2, err_out 0.
REQ-029 Mode 1, angle 512 -> 491 +/-2; angle -512 -> -491 +/-2; mode 0, angle -512 -> 899 +/-2.
REQ-030 Angle 0 -> cos 1024 exactly, sin 0 exactly; angle 1608 (pi/2) -> cos 0 +/-3, sin 1024 +/-3, err_out 0.
REQ-031 Angle 1638 (1.6) -> err_out 1, result_out 0, ready_out on schedule.
REQ-032 Start held high 3 cycles -> single accept; start during DONE -> second result 5 cycles later; result_out stable between.
REQ-033 Reset asserted in ITER -> outputs 0 immediately, no ready_out; rerun with angle 512 -> 899 +/-2; repeat with N_TERMS=6, FRAC=16 -> cos(0.5) = 57513 +/-4.
